// File: rtl/player_pkg.sv
// Shared types and geometry constants for the player motion block.
package player_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } motion_state_t;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned VEL_W    = COORD_W + 1;
  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned FEET_ROW = 14;
  localparam int unsigned PLAT_ROW = 9;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned X_MAX    = SCREEN_W - SPRITE_W;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vsync into the Clk domain and emits a one-cycle pulse per rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_tick;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_meta <= frame_clk;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_tick <= r_sync & ~r_prev;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics (walk, jump, gravity, floor/platform landing) and sprite-local pixel offsets.
module player_motion
  import player_pkg::*;
#(
  parameter int unsigned START_X  = 312,
  parameter int unsigned GROUND_Y = 464,
  parameter int unsigned X_STEP   = 2,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned VMAX     = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_jump,
  input  logic [COORD_W-1:0] plat_x,
  input  logic [COORD_W-1:0] plat_y,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [COORD_W-1:0] PlayerX,
  output logic [COORD_W-1:0] PlayerY,
  output logic [COORD_W-1:0] sprite_x,
  output logic [COORD_W-1:0] sprite_y,
  output logic               in_box,
  output logic               airborne
);

  // Standing on floor/platform means the feet row sits one row above the solid row.
  localparam logic [COORD_W-1:0] STAND_Y   = COORD_W'(GROUND_Y - 1 - FEET_ROW);
  localparam logic [VEL_W-1:0]   FLOOR_ROW = VEL_W'(GROUND_Y - 1);

  logic w_tick;

  frame_tick_sync u_frame_tick_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic signed [VEL_W-1:0] r_vy;
  motion_state_t      r_state;
  logic [COORD_W-1:0] r_sprite_x;
  logic [COORD_W-1:0] r_sprite_y;
  logic               r_in_box;
  logic               r_airborne;

  logic signed [VEL_W-1:0] w_vx;
  logic signed [VEL_W-1:0] w_x_sum;
  logic [COORD_W-1:0]      w_x_next;
  logic                    w_overlap;
  logic [COORD_W-1:0]      w_plat_stand;
  logic                    w_supported;
  logic signed [VEL_W-1:0] w_vy_sum;
  logic signed [VEL_W-1:0] w_vy_new;
  motion_state_t           w_state_mid;
  logic signed [VEL_W-1:0] w_y_next;
  logic [VEL_W-1:0]        w_feet;
  logic [VEL_W-1:0]        w_feet_next;
  logic [VEL_W-1:0]        w_plat_row;
  logic                    w_descending;
  motion_state_t           w_state_next;
  logic signed [VEL_W-1:0] w_vy_next;
  logic [COORD_W-1:0]      w_y_final;
  logic [COORD_W-1:0]      w_dx;
  logic [COORD_W-1:0]      w_dy;

  // Physics step: horizontal move, vertical velocity, then ceiling/landing resolution.
  always_comb begin
    w_vx = '0;
    if (key_right && !key_left) begin
      w_vx = VEL_W'(X_STEP);
    end else if (key_left && !key_right) begin
      w_vx = -VEL_W'(X_STEP);
    end

    w_x_sum = $signed({1'b0, r_x}) + w_vx;
    if (w_x_sum[VEL_W-1]) begin
      w_x_next = '0;
    end else if (w_x_sum > $signed(VEL_W'(X_MAX))) begin
      w_x_next = COORD_W'(X_MAX);
    end else begin
      w_x_next = w_x_sum[COORD_W-1:0];
    end

    w_overlap = (({1'b0, w_x_next} + VEL_W'(SPRITE_W - 1)) >= {1'b0, plat_x}) &&
                ({1'b0, w_x_next} <= ({1'b0, plat_x} + VEL_W'(SPRITE_W - 1)));
    w_plat_stand = plat_y - COORD_W'(FEET_ROW + 1 - PLAT_ROW);
    w_supported  = (r_y == STAND_Y) || ((r_y == w_plat_stand) && w_overlap);

    w_vy_sum    = r_vy + $signed(VEL_W'(GRAVITY));
    w_vy_new    = r_vy;
    w_state_mid = r_state;
    case (r_state)
      GROUNDED: begin
        if (key_jump) begin
          w_vy_new    = -VEL_W'(JUMP_V);
          w_state_mid = RISING;
        end else begin
          w_vy_new = '0;
          if (!w_supported) begin
            w_state_mid = FALLING;
          end
        end
      end
      default: begin
        w_vy_new = (w_vy_sum > $signed(VEL_W'(VMAX))) ? $signed(VEL_W'(VMAX)) : w_vy_sum;
        if (r_state == RISING && !w_vy_new[VEL_W-1]) begin
          w_state_mid = FALLING;
        end
      end
    endcase

    w_y_next     = $signed({1'b0, r_y}) + w_vy_new;
    w_feet       = {1'b0, r_y} + VEL_W'(FEET_ROW);
    w_feet_next  = $unsigned(w_y_next) + VEL_W'(FEET_ROW);
    w_plat_row   = {1'b0, plat_y} + VEL_W'(PLAT_ROW);
    w_descending = (w_state_mid == FALLING) && !w_vy_new[VEL_W-1] && (w_vy_new != '0);

    w_state_next = w_state_mid;
    w_vy_next    = w_vy_new;
    w_y_final    = w_y_next[COORD_W-1:0];
    if (w_y_next[VEL_W-1]) begin
      w_state_next = FALLING;
      w_vy_next    = '0;
      w_y_final    = '0;
    end else if (w_descending && w_overlap && (w_feet < w_plat_row) && (w_feet_next >= w_plat_row)) begin
      w_state_next = GROUNDED;
      w_vy_next    = '0;
      w_y_final    = w_plat_stand;
    end else if (w_descending && (w_feet_next >= FLOOR_ROW)) begin
      w_state_next = GROUNDED;
      w_vy_next    = '0;
      w_y_final    = STAND_Y;
    end
  end

  assign w_dx = DrawX - r_x;
  assign w_dy = DrawY - r_y;

  // Motion state advances only on a frame tick; the pixel offsets are registered every cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_x        <= COORD_W'(START_X);
      r_y        <= STAND_Y;
      r_vy       <= '0;
      r_state    <= GROUNDED;
      r_airborne <= 1'b0;
      r_sprite_x <= '0;
      r_sprite_y <= '0;
      r_in_box   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_x        <= w_x_next;
        r_y        <= w_y_final;
        r_vy       <= w_vy_next;
        r_state    <= w_state_next;
        r_airborne <= (w_state_next != GROUNDED);
      end
      r_sprite_x <= w_dx;
      r_sprite_y <= w_dy;
      r_in_box   <= (w_dx < COORD_W'(SPRITE_W)) && (w_dy < COORD_W'(SPRITE_W));
    end
  end

  assign PlayerX  = r_x;
  assign PlayerY  = r_y;
  assign sprite_x = r_sprite_x;
  assign sprite_y = r_sprite_y;
  assign in_box   = r_in_box;
  assign airborne = r_airborne;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: directed scenarios plus randomized frames against an integer model.
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic [9:0] plat_x = 10'd100;
  logic [9:0] plat_y = 10'd200;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [9:0] PlayerX, PlayerY, sprite_x, sprite_y;
  logic       in_box, airborne;

  player_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .plat_x(plat_x), .plat_y(plat_y), .DrawX(DrawX), .DrawY(DrawY),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .in_box(in_box), .airborne(airborne)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int x; int y; int air; } pos_t;
  typedef struct { int cyc; int sx; int sy; int inb; } pix_t;
  pos_t pos_q[$];
  pix_t pix_q[$];

  // Reference model: 0 grounded, 1 rising, 2 falling.
  int mx, my, mvy, mst, px, py;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 312; my = 449; mvy = 0; mst = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j);
    int vx, xn, vyn, yn;
    bit ov, sup, down;
    vx = (r && !l) ? 2 : ((l && !r) ? -2 : 0);
    xn = mx + vx;
    if (xn < 0) xn = 0;
    if (xn > 624) xn = 624;
    ov  = (xn + 15 >= px) && (xn <= px + 15);
    sup = (my == 449) || (my == py - 6 && ov);
    if (mst == 0) begin
      vyn = 0;
      if (j) begin vyn = -12; mst = 1; end
      else if (!sup) mst = 2;
    end else begin
      vyn = (mvy + 1 > 8) ? 8 : mvy + 1;
      if (mst == 1 && vyn >= 0) mst = 2;
    end
    yn = my + vyn;
    down = (mst == 2) && (vyn > 0);
    if (yn < 0) begin
      my = 0; mvy = 0; mst = 2;
    end else if (down && ov && (my + 14 < py + 9) && (yn + 14 >= py + 9)) begin
      my = py - 6; mvy = 0; mst = 0;
    end else if (down && (yn + 14 >= 463)) begin
      my = 449; mvy = 0; mst = 0;
    end else begin
      my = yn; mvy = vyn;
    end
    mx = xn;
  endtask

  task automatic do_frame(input bit l, input bit r, input bit j, input int hold);
    pos_t e;
    @(negedge Clk);
    key_left = l; key_right = r; key_jump = j;
    model_step(l, r, j);
    e.x = mx; e.y = my; e.air = (mst != 0) ? 1 : 0;
    pos_q.push_back(e);
    frame_clk = 1'b1;
    repeat (hold) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic pix_check(input int dx, input int dy);
    pix_t p;
    @(negedge Clk);
    DrawX = 10'((mx + dx) & 1023);
    DrawY = 10'((my + dy) & 1023);
    p.cyc = cyc;
    p.sx  = dx & 1023;
    p.sy  = dy & 1023;
    p.inb = (dx >= 0 && dx <= 15 && dy >= 0 && dy <= 15) ? 1 : 0;
    pix_q.push_back(p);
  endtask

  // Position monitor: the DUT has settled by the time the bench drops frame_clk.
  initial begin
    pos_t e;
    forever begin
      @(negedge frame_clk);
      if (pos_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_queue_empty actual=0 entries required=1");
      end else begin
        e = pos_q.pop_front();
        chk("frame_PlayerX", int'(PlayerX), e.x);
        chk("frame_PlayerY", int'(PlayerY), e.y);
        chk("frame_airborne", int'(airborne), e.air);
      end
    end
  end

  // Pixel monitor: each request is compared one clock after it was driven.
  initial begin
    pix_t p;
    forever begin
      @(negedge Clk);
      if (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
        p = pix_q.pop_front();
        chk("pix_sprite_x", int'(sprite_x), p.sx);
        chk("pix_sprite_y", int'(sprite_y), p.sy);
        chk("pix_in_box", int'(in_box), p.inb);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, x0, dx, dy;
    px = 100; py = 200;
    model_reset();
    repeat (4) @(negedge Clk);
    chk("reset_PlayerX", int'(PlayerX), 312);
    chk("reset_PlayerY", int'(PlayerY), 449);
    chk("reset_airborne", int'(airborne), 0);
    chk("reset_in_box", int'(in_box), 0);
    chk("reset_sprite_x", int'(sprite_x), 0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    for (int i = 0; i < 10; i++) do_frame(0, 1, 0, 8);
    chk("walk_right_10", int'(PlayerX), 332);
    for (int i = 0; i < 3; i++) do_frame(1, 1, 0, 8);
    chk("both_keys_x", int'(PlayerX), 332);

    pix_check(3, 15);
    pix_check(3, 16);
    pix_check(0, 0);
    pix_check(-1, 5);
    repeat (3) @(negedge Clk);

    guard = 0;
    while (mx != 624 && guard < 200) begin do_frame(0, 1, 0, 8); guard++; end
    chk("right_edge_x", int'(PlayerX), 624);
    do_frame(0, 1, 0, 8);
    chk("right_clamp_x", int'(PlayerX), 624);

    do_frame(0, 0, 1, 8);
    chk("jump_y1", int'(PlayerY), 437);
    do_frame(0, 0, 0, 8);
    chk("jump_y2", int'(PlayerY), 426);
    for (int i = 0; i < 11; i++) do_frame(0, 0, 0, 8);
    chk("apex_y", int'(PlayerY), 371);
    chk("apex_airborne", int'(airborne), 1);
    guard = 0;
    while (mst != 0 && guard < 40) begin do_frame(0, 0, 0, 8); guard++; end
    chk("floor_land_y", int'(PlayerY), 449);
    chk("floor_land_air", int'(airborne), 0);

    px = 300; py = 420;
    plat_x = 10'd300; plat_y = 10'd420;
    guard = 0;
    while (mx != 304 && guard < 200) begin do_frame(1, 0, 0, 8); guard++; end
    do_frame(0, 0, 1, 8);
    guard = 0;
    while (mst != 0 && guard < 40) begin do_frame(0, 0, 0, 8); guard++; end
    chk("plat_land_y", int'(PlayerY), 414);
    chk("plat_land_air", int'(airborne), 0);
    guard = 0;
    while (mx != 316 && guard < 20) begin do_frame(0, 1, 0, 8); guard++; end
    chk("walk_off_x", int'(PlayerX), 316);
    chk("walk_off_air", int'(airborne), 1);
    guard = 0;
    while (mst != 0 && guard < 40) begin do_frame(0, 0, 0, 8); guard++; end
    chk("walk_off_floor_y", int'(PlayerY), 449);

    x0 = mx;
    do_frame(1, 0, 0, 5000);
    chk("long_frame_one_step", int'(PlayerX), x0 - 2);
    repeat (200) @(negedge Clk);
    chk("no_frame_no_motion", int'(PlayerX), x0 - 2);

    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        px = $urandom_range(0, 624);
        py = $urandom_range(100, 440);
        plat_x = 10'(px); plat_y = 10'(py);
      end
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), $urandom_range(8, 20));
      dx = $urandom_range(0, 24); dx = dx - 4;
      dy = $urandom_range(0, 24); dy = dy - 4;
      pix_check(dx, dy);
    end
    repeat (3) @(negedge Clk);

    do_frame(0, 0, 1, 8);
    do_frame(0, 0, 0, 8);
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clk);
    chk("midair_reset_x", int'(PlayerX), 312);
    chk("midair_reset_y", int'(PlayerY), 449);
    chk("midair_reset_air", int'(airborne), 0);
    Reset_n = 1'b1;
    key_jump = 1'b0;
    repeat (4) @(negedge Clk);
    do_frame(0, 1, 0, 8);

    repeat (5) @(negedge Clk);
    n_tests++;
    if (pos_q.size() != 0 || pix_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained actual=%0d/%0d required=0/0", pos_q.size(), pix_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
